// File: rtl/elevator_pkg.sv
// Shared types for the elevator car controller: floor type, car state
// encoding and a small compile-time helper for sizing the phase timer.
package elevator_pkg;

  localparam int FLOOR_W = 3;

  typedef logic [FLOOR_W-1:0] floor_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UP     = 3'd1,
    DOWN   = 3'd2,
    SETTLE = 3'd3,
    DOOR   = 3'd4,
    HALT   = 3'd5
  } car_state_t;

  // Larger of two integers, used at elaboration time for timer width.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/elevator_car_ctrl_timer.sv
// elev_timer: loadable down-counter shared by the travel and door phases.
// Load wins over decrement; the count parks at zero and reports it on 'zero'.
module elev_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load a new phase length, or step down toward zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/elevator_car_ctrl.sv
// elevator_car_ctrl: motion/door sequencer. Consumes dest_less/dest_more from
// the floor-vs-destination compare stage, owns the car position register and
// steps the car one floor per TRAVEL_CYCLES (plus one SETTLE cycle), then holds
// the door open for DOOR_CYCLES.
// Optional feature: define ELEV_ESTOP_EN to enable the emergency-stop HALT
// state; without it the estop input is ignored.
// dbg_state exposes the FSM state register for checkers.
module elevator_car_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 100,
  parameter int DOOR_CYCLES   = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dest_less,
  input  logic       dest_more,
  input  logic       estop,
  output floor_t     floor,
  output logic       moving_up,
  output logic       moving_down,
  output logic       door_open,
  output logic       arrived,
  output logic       busy,
  output car_state_t dbg_state
);

  localparam int              TW          = $clog2(max2(TRAVEL_CYCLES, DOOR_CYCLES));
  localparam logic [TW-1:0]   TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0]   DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
  localparam floor_t          TOP_FLOOR   = floor_t'(NUM_FLOORS - 1);

  car_state_t    state_q, state_d;
  floor_t        floor_q, floor_d;
  logic          moving_up_q, moving_up_d;
  logic          moving_down_q, moving_down_d;
  logic          door_open_q, door_open_d;
  logic          arrived_q, arrived_d;
  logic          busy_q, busy_d;

  logic          t_load;
  logic [TW-1:0] t_load_val;
  logic          t_en;
  logic          t_zero;

  // Legal move requests: exactly one flag set and the car not at that end floor.
  logic          go_up;
  logic          go_down;

  assign go_up   = dest_more && !dest_less && (floor_q < TOP_FLOOR);
  assign go_down = dest_less && !dest_more && (floor_q != '0);

`ifndef ELEV_ESTOP_EN
  // Emergency stop is not built in this configuration.
  logic estop_unused;
  assign estop_unused = estop;
`endif

  elev_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_load_val),
    .en       (t_en),
    .zero     (t_zero)
  );

  // Next-state, floor update and timer control.
  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    t_load     = 1'b0;
    t_load_val = '0;
    t_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (go_up) begin
          state_d    = UP;
          t_load     = 1'b1;
          t_load_val = TRAVEL_LOAD;
        end else if (go_down) begin
          state_d    = DOWN;
          t_load     = 1'b1;
          t_load_val = TRAVEL_LOAD;
        end
      end
      UP: begin
        if (t_zero) begin
          floor_d = floor_q + floor_t'(1);
          state_d = SETTLE;
        end else begin
          t_en = 1'b1;
        end
      end
      DOWN: begin
        if (t_zero) begin
          floor_d = floor_q - floor_t'(1);
          state_d = SETTLE;
        end else begin
          t_en = 1'b1;
        end
      end
      SETTLE: begin
        // Flags now reflect the new floor; continue, reverse, or stop.
        if (go_up) begin
          state_d    = UP;
          t_load     = 1'b1;
          t_load_val = TRAVEL_LOAD;
        end else if (go_down) begin
          state_d    = DOWN;
          t_load     = 1'b1;
          t_load_val = TRAVEL_LOAD;
        end else begin
          state_d    = DOOR;
          t_load     = 1'b1;
          t_load_val = DOOR_LOAD;
        end
      end
      DOOR: begin
        if (t_zero) begin
          state_d = IDLE;
        end else begin
          t_en = 1'b1;
        end
      end
      HALT: begin
`ifdef ELEV_ESTOP_EN
        if (!estop) begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef ELEV_ESTOP_EN
    // Emergency stop overrides everything: freeze timer and floor.
    if (estop) begin
      state_d = HALT;
      floor_d = floor_q;
      t_load  = 1'b0;
      t_en    = 1'b0;
    end
`endif
  end

  // Output decode from the next state so registered outputs align with state_q.
  always_comb begin
    moving_up_d   = (state_d == UP);
    moving_down_d = (state_d == DOWN);
    door_open_d   = (state_d == DOOR);
    arrived_d     = (state_d == DOOR) && (state_q != DOOR);
    busy_d        = (state_d != IDLE);
  end

  // State, position and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      floor_q       <= '0;
      moving_up_q   <= 1'b0;
      moving_down_q <= 1'b0;
      door_open_q   <= 1'b0;
      arrived_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      floor_q       <= floor_d;
      moving_up_q   <= moving_up_d;
      moving_down_q <= moving_down_d;
      door_open_q   <= door_open_d;
      arrived_q     <= arrived_d;
      busy_q        <= busy_d;
    end
  end

  assign floor       = floor_q;
  assign moving_up   = moving_up_q;
  assign moving_down = moving_down_q;
  assign door_open   = door_open_q;
  assign arrived     = arrived_q;
  assign busy        = busy_q;
  assign dbg_state   = state_q;

endmodule
